// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, bubble encoding, default PC width.
package cpu_pkg;

  localparam int          PC_W_DEFAULT      = 8;
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'hE000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats load; with nothing to load and
// no hold it takes a bubble so decode never sees the same word twice.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEFAULT,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            hold,
  input  logic [15:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  output logic [15:0]     instruction,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= NOP_INSTR;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (flush || (!hold && !load)) begin
      // pc_out keeps the last real address; only the word and its valid bit change
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (!hold) begin
      instruction <= instr_in;
      pc_out      <= pc_in;
      instr_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM, PC, one-entry skid buffer and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds a saturating count of real IF/ID loads.
//
// state    | meaning
// ST_IDLE  | after reset, no request; next cycle starts fetching
// ST_FETCH | imem_req=1 at PC, waiting for imem_valid
// ST_HOLD  | word parked in skid buffer while decode is stalled
// ST_DRAIN | redirect left a response in flight; drop it, then fetch
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instruction,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid,
  output logic [15:0]     fetch_count
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     skid_data;
  logic [PC_W-1:0] skid_pc;
  logic            skid_full;
  logic            skid_set, skid_clr;
  logic            ifid_load, ifid_from_skid;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    skid_set       = 1'b0;
    skid_clr       = 1'b0;
    ifid_load      = 1'b0;
    ifid_from_skid = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
        if (redirect) pc_nxt = redirect_pc;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = imem_valid ? ST_FETCH : ST_DRAIN;
        end else if (imem_valid) begin
          pc_nxt = pc + PC_ONE;
          if (stall) begin
            skid_set  = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          skid_clr  = 1'b1;
          state_nxt = ST_FETCH;
        end else if (!stall) begin
          ifid_load      = skid_full;
          ifid_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_nxt      = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_nxt = redirect_pc;
        // the in-flight response is consumed here even if a new redirect arrives with it
        if (imem_valid) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      skid_full <= 1'b0;
      skid_data <= NOP_INSTR;
      skid_pc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (skid_clr || redirect) begin
        skid_full <= 1'b0;
      end else if (skid_set) begin
        skid_full <= 1'b1;
        skid_data <= imem_rdata;
        skid_pc   <= pc;
      end
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .flush       (redirect),
    .hold        (stall),
    .instr_in    (ifid_from_skid ? skid_data : imem_rdata),
    .pc_in       (ifid_from_skid ? skid_pc : pc),
    .instruction (instruction),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
    end else if (ifid_load && (fetch_cnt != 16'hFFFF)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  assign fetch_count = fetch_cnt;
`else
  assign fetch_count = '0;
`endif

endmodule
